reorder_buffer: RTL and testbench
=================================

# reorder_buffer

Parametrised reorder buffer for the out-of-order RV32I core: it replaces the fixed single-result-port ROB. It holds issued instructions in program order and accepts results from `NUM_CDB` broadcast channels. It commits up to `COMMIT_W` entries per cycle to the register file and LSB, and resolves branch/JALR mispredictions by a one-cycle rollback pulse and a PC redirect to IFetch. Sits between decoder/issue, ALU/LSB result buses, regfile, LSB and predictor.

## Interface
Parameters:
- `ROB_AW`, 4: index width; depth `ROB_DEPTH = 2**ROB_AW`, and `ROB_AW` ≥ 2.
- `NUM_CDB`, 2: number of result broadcast channels, 1..4.
- `COMMIT_W`, 1: commits per cycle, 1 or 2.

Ports (name, direction, width, meaning). Opcode width and encodings come from the shared size header.
- `clk` in 1: single clock.
- `rst` in 1: synchronous, active-high reset.
- `rdy` in 1: global enable; low freezes all state.
- `rollback` out 1: flush pulse.
- `rob_nxt_full` out 1: ROB full next cycle.
- `cdb_valid` in NUM_CDB: per-channel result valid.
- `cdb_rob_pos` in NUM_CDB*ROB_AW: per-channel entry index.
- `cdb_val` in NUM_CDB*32: result value.
- `cdb_jump` in NUM_CDB: resolved taken; LSB channels drive 0.
- `cdb_pc` in NUM_CDB*32: resolved target PC.
- `issue` in 1: allocate entry at tail.
- `issue_rd` in 5, `issue_opcode` in OPCODE, `issue_pc` in 32, `issue_pred_jump` in 1, `issue_is_ready` in 1: contents of the new entry.
- `nxt_rob_pos` out ROB_AW: current tail.
- `head_rob_pos` out ROB_AW: current head.
- `rs1_pos`/`rs2_pos` in ROB_AW: operand query.
- `rs1_ready`/`rs2_ready` out 1: operand query result.
- `rs1_val`/`rs2_val` out 32: operand query result.
- `reg_write` out COMMIT_W: regfile write enables.
- `reg_rd` out COMMIT_W*5, `reg_val` out COMMIT_W*32: regfile write data.
- `lsb_store` out 1: store commit pulse.
- `commit_rob_pos` out ROB_AW: oldest entry committed this cycle.
- `if_set_pc_en` out 1, `if_set_pc` out 32: redirect to IFetch.
- `commit_br` out 1, `commit_br_jump` out 1, `commit_br_pc` out 32: predictor update.

## Operation
- Circular buffer. State: `head`, `tail` (ROB_AW bits, natural wrap) and `count` (ROB_AW+1 bits); no separate empty flag.
- Entry fields: ready, rd, opcode, pc, val, pred_jump, res_jump, res_pc.
- Issue writes the entry at `tail` and sets ready to `issue_is_ready`; `tail` then increments. Issuing while full is illegal; the caller gates issue on `rob_nxt_full`.
- CDB: for each valid channel, write val, res_jump and res_pc into the target entry and set ready. If two channels target the same entry, the higher channel index wins.
- Commit slot 0 fires when `count>0` and `ready[head]`.
- Commit slot 1 (only when COMMIT_W=2) fires when all of the following hold:
  - slot 0 fires and `count>1`;
  - `ready[head+1]`;
  - neither entry is BR, JALR or S.
- Per committed entry:
  - S: `lsb_store`=1.
  - BR: `commit_br`=1 with res_jump and pc; no regfile write.
  - Every other opcode, including JALR: regfile write of rd/val in its slot.
  - BR/JALR with `pred_jump != res_jump`: rollback=1, `if_set_pc_en`=1, `if_set_pc`=res_pc.
- `count_nxt = count + issue − commits`; `rob_nxt_full = (count_nxt == ROB_DEPTH)`, combinational.
- Query outputs are combinational reads of the ready/val arrays.
- Rollback cycle (rollback=1): behaves exactly like reset.
  - head, tail and count go to 0; all ready bits clear.
  - All pulse outputs go to 0; issue and CDB inputs are ignored.

## Timing
- Reset values: all outputs 0. `rob_nxt_full`=0 and the query ready outputs are 0.
- All commit-side outputs are registered single-cycle pulses. `reg_rd`, `reg_val`, `commit_rob_pos`, `commit_br_jump` and `commit_br_pc` hold their value between commits.
- CDB result at cycle t: entry ready at t+1, commit outputs at t+2 if the entry is at head.
- Issue with `issue_is_ready`=1 at t into an empty ROB: commit outputs at t+2.
- Mispredict detected at the head at t: `rollback`/`if_set_pc_en` high during t+1 only; ROB empty at t+2.
- Simultaneous issue and commit when full: legal; count stays at ROB_DEPTH and `rob_nxt_full` stays 1.
- Simultaneous issue and commit on an empty ROB (the entry is not yet ready): count goes to 1.
- `rdy`=0: no state or output changes.

## Configuration
- `ROB_BYPASS_EN` defined: the rs query also matches the current-cycle CDB. If any valid channel targets `rsX_pos`, then `rsX_ready`=1 and `rsX_val`=that channel's value (highest index wins).
- Macro absent: the query reflects registered state only, so the result is visible one cycle after the broadcast.

## Test plan
- Reset, then issue 16 entries with ready=0 (ROB_AW=4) -> `rob_nxt_full`=1 in the cycle of the 16th issue. Then CDB-complete entry 0 -> commit at t+2, `commit_rob_pos`=0, full drops.
- Issue ADDI rd=5, ready=1; CDB val=0x1234 on channel 1 -> `reg_write`[0]=1, `reg_rd`=5, `reg_val`=0x1234.
- COMMIT_W=2 with two ready ALU ops at head -> `reg_write`=2'b11 in one cycle. Replace the second with an S -> it commits the next cycle with `lsb_store`=1.
- BR pred_jump=0, CDB jump=1, pc=0x80 -> `commit_br`=1, then `rollback`=1, `if_set_pc_en`=1, `if_set_pc`=0x80, head=tail=0 in the following cycle.
- Head/tail wrap: 40 issue/commit pairs at depth 16 -> in-order `commit_rob_pos` 0..15 repeating; no spurious full.
- With `ROB_BYPASS_EN`: query pos 3 in the same cycle as a CDB to pos 3 with val 0x55 -> `rs1_ready`=1, `rs1_val`=0x55. Without the macro -> `rs1_ready`=0 that cycle and 1 the next.

Source files
------------

// File: rtl/reorder_buffer.sv
// reorder_buffer: circular in-order commit buffer with NUM_CDB result ports.
// Optional macro ROB_BYPASS_EN forwards same-cycle CDB results to rs queries.
module reorder_buffer #(
    parameter int ROB_AW   = 4,
    parameter int NUM_CDB  = 2,
    parameter int COMMIT_W = 1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    rdy,
    output logic                    rollback,
    output logic                    rob_nxt_full,
    input  logic [NUM_CDB-1:0]      cdb_valid,
    input  logic [NUM_CDB*ROB_AW-1:0] cdb_rob_pos,
    input  logic [NUM_CDB*32-1:0]   cdb_val,
    input  logic [NUM_CDB-1:0]      cdb_jump,
    input  logic [NUM_CDB*32-1:0]   cdb_pc,
    input  logic                    issue,
    input  logic [4:0]              issue_rd,
    input  logic [6:0]              issue_opcode,
    input  logic [31:0]             issue_pc,
    input  logic                    issue_pred_jump,
    input  logic                    issue_is_ready,
    output logic [ROB_AW-1:0]       nxt_rob_pos,
    output logic [ROB_AW-1:0]       head_rob_pos,
    input  logic [ROB_AW-1:0]       rs1_pos,
    input  logic [ROB_AW-1:0]       rs2_pos,
    output logic                    rs1_ready,
    output logic                    rs2_ready,
    output logic [31:0]             rs1_val,
    output logic [31:0]             rs2_val,
    output logic [COMMIT_W-1:0]     reg_write,
    output logic [COMMIT_W*5-1:0]   reg_rd,
    output logic [COMMIT_W*32-1:0]  reg_val,
    output logic                    lsb_store,
    output logic [ROB_AW-1:0]       commit_rob_pos,
    output logic                    if_set_pc_en,
    output logic [31:0]             if_set_pc,
    output logic                    commit_br,
    output logic                    commit_br_jump,
    output logic [31:0]             commit_br_pc
);
    localparam int ROB_DEPTH = 2 ** ROB_AW;
    localparam logic [6:0] OP_BR   = 7'b1100011;
    localparam logic [6:0] OP_JALR = 7'b1100111;
    localparam logic [6:0] OP_S    = 7'b0100011;

    logic [ROB_AW-1:0]    head, tail, head1;
    logic [ROB_AW:0]      count, count_nxt, n_commit;
    logic [ROB_DEPTH-1:0] ready_q;
    logic [4:0]           rd_q     [ROB_DEPTH];
    logic [6:0]           op_q     [ROB_DEPTH];
    logic [31:0]          pc_q     [ROB_DEPTH];
    logic [31:0]          val_q    [ROB_DEPTH];
    logic [31:0]          res_pc_q [ROB_DEPTH];
    logic                 pred_q   [ROB_DEPTH];
    logic                 jump_q   [ROB_DEPTH];
    logic                 fire0, fire1, mispredict, flush;
    logic [6:0]           h_op;
    logic [COMMIT_W-1:0]  slot_we;

    function automatic logic is_ctl(input logic [6:0] op);
        return (op == OP_BR) || (op == OP_JALR) || (op == OP_S);
    endfunction

    assign nxt_rob_pos  = tail;
    assign head_rob_pos = head;
    assign flush        = rst || rollback;
    assign rob_nxt_full = (count_nxt == (ROB_AW+1)'(ROB_DEPTH));

    // Commit slot selection and misprediction detection at the head.
    always_comb begin
        head1 = head + ROB_AW'(1);
        h_op  = op_q[head];
        fire0 = (count != '0) && ready_q[head];
        fire1 = 1'b0;
        if (COMMIT_W == 2)
            fire1 = fire0 && (count > (ROB_AW+1)'(1)) && ready_q[head1]
                    && !is_ctl(h_op) && !is_ctl(op_q[head1]);
        n_commit   = (ROB_AW+1)'(fire0) + (ROB_AW+1)'(fire1);
        mispredict = fire0 && ((h_op == OP_BR) || (h_op == OP_JALR))
                     && (pred_q[head] != jump_q[head]);
        slot_we    = '0;
        slot_we[0] = fire0 && (h_op != OP_BR) && (h_op != OP_S);
        if (COMMIT_W == 2)
            slot_we[COMMIT_W-1] = fire1;
    end

    // Occupancy seen at the next edge; drives the full lookahead.
    always_comb begin
        count_nxt = count;
        if (flush)
            count_nxt = '0;
        else if (rdy)
            count_nxt = count + (ROB_AW+1)'(issue) - n_commit;
    end

    // Operand query, optionally forwarding the current-cycle broadcast.
    always_comb begin
        rs1_ready = ready_q[rs1_pos];
        rs1_val   = val_q[rs1_pos];
        rs2_ready = ready_q[rs2_pos];
        rs2_val   = val_q[rs2_pos];
`ifdef ROB_BYPASS_EN
        for (int c = 0; c < NUM_CDB; c++) begin
            if (cdb_valid[c] && cdb_rob_pos[c*ROB_AW +: ROB_AW] == rs1_pos) begin
                rs1_ready = 1'b1;
                rs1_val   = cdb_val[c*32 +: 32];
            end
            if (cdb_valid[c] && cdb_rob_pos[c*ROB_AW +: ROB_AW] == rs2_pos) begin
                rs2_ready = 1'b1;
                rs2_val   = cdb_val[c*32 +: 32];
            end
        end
`endif
    end

    // Entry payload: issue fields at tail, results from each CDB channel.
    always_ff @(posedge clk) begin
        if (rdy && !flush) begin
            if (issue) begin
                rd_q[tail]   <= issue_rd;
                op_q[tail]   <= issue_opcode;
                pc_q[tail]   <= issue_pc;
                pred_q[tail] <= issue_pred_jump;
            end
            for (int c = 0; c < NUM_CDB; c++) begin
                if (cdb_valid[c]) begin
                    val_q[cdb_rob_pos[c*ROB_AW +: ROB_AW]]    <= cdb_val[c*32 +: 32];
                    jump_q[cdb_rob_pos[c*ROB_AW +: ROB_AW]]   <= cdb_jump[c];
                    res_pc_q[cdb_rob_pos[c*ROB_AW +: ROB_AW]] <= cdb_pc[c*32 +: 32];
                end
            end
        end
    end

    // Pointers, ready bits and registered commit outputs; rollback acts as reset.
    always_ff @(posedge clk) begin
        if (flush) begin
            head           <= '0;
            tail           <= '0;
            count          <= '0;
            ready_q        <= '0;
            rollback       <= 1'b0;
            if_set_pc_en   <= 1'b0;
            if_set_pc      <= '0;
            lsb_store      <= 1'b0;
            commit_br      <= 1'b0;
            commit_br_jump <= 1'b0;
            commit_br_pc   <= '0;
            commit_rob_pos <= '0;
            reg_write      <= '0;
            reg_rd         <= '0;
            reg_val        <= '0;
        end else if (rdy) begin
            if (issue) begin
                ready_q[tail] <= issue_is_ready;
                tail          <= tail + ROB_AW'(1);
            end
            for (int c = 0; c < NUM_CDB; c++)
                if (cdb_valid[c])
                    ready_q[cdb_rob_pos[c*ROB_AW +: ROB_AW]] <= 1'b1;
            head  <= head + n_commit[ROB_AW-1:0];
            count <= count_nxt;

            rollback     <= mispredict;
            if_set_pc_en <= mispredict;
            if (mispredict)
                if_set_pc <= res_pc_q[head];
            lsb_store <= fire0 && (h_op == OP_S);
            commit_br <= fire0 && (h_op == OP_BR);
            if (fire0 && (h_op == OP_BR)) begin
                commit_br_jump <= jump_q[head];
                commit_br_pc   <= pc_q[head];
            end
            if (fire0)
                commit_rob_pos <= head;
            for (int k = 0; k < COMMIT_W; k++) begin
                reg_write[k] <= slot_we[k];
                if (slot_we[k]) begin
                    reg_rd[k*5 +: 5]   <= rd_q[head + ROB_AW'(k)];
                    reg_val[k*32 +: 32] <= val_q[head + ROB_AW'(k)];
                end
            end
        end
    end
endmodule

// File: tb/tb_reorder_buffer.sv
// tb_reorder_buffer: directed checks of issue, CDB, commit, rollback, wrap.
// Second instance uses COMMIT_W=2 and shares all inputs.
module tb_reorder_buffer;
    localparam logic [6:0] OP_ADD  = 7'b0110011;
    localparam logic [6:0] OP_ADDI = 7'b0010011;
    localparam logic [6:0] OP_BR   = 7'b1100011;
    localparam logic [6:0] OP_S    = 7'b0100011;

    logic        clk = 1'b0;
    logic        rst, rdy;
    logic [1:0]  cdb_valid, cdb_jump;
    logic [7:0]  cdb_rob_pos;
    logic [63:0] cdb_val, cdb_pc;
    logic        issue, issue_pred_jump, issue_is_ready;
    logic [4:0]  issue_rd;
    logic [6:0]  issue_opcode;
    logic [31:0] issue_pc;
    logic [3:0]  rs1_pos, rs2_pos;

    logic        rollback, rob_nxt_full, rs1_ready, rs2_ready;
    logic        lsb_store, if_set_pc_en, commit_br, commit_br_jump;
    logic [3:0]  nxt_rob_pos, head_rob_pos, commit_rob_pos;
    logic [31:0] rs1_val, rs2_val, if_set_pc, commit_br_pc;
    logic [0:0]  reg_write;
    logic [4:0]  reg_rd;
    logic [31:0] reg_val;

    logic        d2_rollback, d2_full, d2_rs1_ready, d2_rs2_ready;
    logic        d2_lsb_store, d2_pc_en, d2_br, d2_br_jump;
    logic [3:0]  d2_nxt, d2_head, d2_cpos;
    logic [31:0] d2_rs1_val, d2_rs2_val, d2_set_pc, d2_br_pc;
    logic [1:0]  d2_reg_write;
    logic [9:0]  d2_reg_rd;
    logic [63:0] d2_reg_val;

    int nerr = 0;
    int nchk = 0;

    always #5 clk = ~clk;

    reorder_buffer #(.ROB_AW(4), .NUM_CDB(2), .COMMIT_W(1)) dut (
        .clk(clk), .rst(rst), .rdy(rdy), .rollback(rollback),
        .rob_nxt_full(rob_nxt_full), .cdb_valid(cdb_valid),
        .cdb_rob_pos(cdb_rob_pos), .cdb_val(cdb_val), .cdb_jump(cdb_jump),
        .cdb_pc(cdb_pc), .issue(issue), .issue_rd(issue_rd),
        .issue_opcode(issue_opcode), .issue_pc(issue_pc),
        .issue_pred_jump(issue_pred_jump), .issue_is_ready(issue_is_ready),
        .nxt_rob_pos(nxt_rob_pos), .head_rob_pos(head_rob_pos),
        .rs1_pos(rs1_pos), .rs2_pos(rs2_pos), .rs1_ready(rs1_ready),
        .rs2_ready(rs2_ready), .rs1_val(rs1_val), .rs2_val(rs2_val),
        .reg_write(reg_write), .reg_rd(reg_rd), .reg_val(reg_val),
        .lsb_store(lsb_store), .commit_rob_pos(commit_rob_pos),
        .if_set_pc_en(if_set_pc_en), .if_set_pc(if_set_pc),
        .commit_br(commit_br), .commit_br_jump(commit_br_jump),
        .commit_br_pc(commit_br_pc)
    );

    reorder_buffer #(.ROB_AW(4), .NUM_CDB(2), .COMMIT_W(2)) dut2 (
        .clk(clk), .rst(rst), .rdy(rdy), .rollback(d2_rollback),
        .rob_nxt_full(d2_full), .cdb_valid(cdb_valid),
        .cdb_rob_pos(cdb_rob_pos), .cdb_val(cdb_val), .cdb_jump(cdb_jump),
        .cdb_pc(cdb_pc), .issue(issue), .issue_rd(issue_rd),
        .issue_opcode(issue_opcode), .issue_pc(issue_pc),
        .issue_pred_jump(issue_pred_jump), .issue_is_ready(issue_is_ready),
        .nxt_rob_pos(d2_nxt), .head_rob_pos(d2_head),
        .rs1_pos(rs1_pos), .rs2_pos(rs2_pos), .rs1_ready(d2_rs1_ready),
        .rs2_ready(d2_rs2_ready), .rs1_val(d2_rs1_val), .rs2_val(d2_rs2_val),
        .reg_write(d2_reg_write), .reg_rd(d2_reg_rd), .reg_val(d2_reg_val),
        .lsb_store(d2_lsb_store), .commit_rob_pos(d2_cpos),
        .if_set_pc_en(d2_pc_en), .if_set_pc(d2_set_pc),
        .commit_br(d2_br), .commit_br_jump(d2_br_jump),
        .commit_br_pc(d2_br_pc)
    );

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        nchk++;
        assert (got === exp) else begin
            nerr++;
            $error("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        issue       = 1'b0;
        cdb_valid   = '0;
        cdb_jump    = '0;
        cdb_rob_pos = '0;
        cdb_val     = '0;
        cdb_pc      = '0;
    endtask

    task automatic put(input logic [4:0] rd, input logic [6:0] op,
                       input logic [31:0] pc, input logic pj,
                       input logic rdyin);
        issue           = 1'b1;
        issue_rd        = rd;
        issue_opcode    = op;
        issue_pc        = pc;
        issue_pred_jump = pj;
        issue_is_ready  = rdyin;
    endtask

    task automatic cdb(input int ch, input logic [3:0] pos,
                       input logic [31:0] v, input logic j,
                       input logic [31:0] pc);
        cdb_valid[ch]          = 1'b1;
        cdb_rob_pos[ch*4 +: 4] = pos;
        cdb_val[ch*32 +: 32]   = v;
        cdb_jump[ch]           = j;
        cdb_pc[ch*32 +: 32]    = pc;
    endtask

    task automatic do_reset();
        idle();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        #1;
    endtask

    initial begin
        rdy = 1'b1;
        rs1_pos = '0;
        rs2_pos = '0;
        put(5'd0, OP_ADD, 32'd0, 1'b0, 1'b0);
        do_reset();
        chk("rst_rollback", 32'(rollback), 32'd0);
        chk("rst_full", 32'(rob_nxt_full), 32'd0);
        chk("rst_rs1_ready", 32'(rs1_ready), 32'd0);
        chk("rst_head", 32'(head_rob_pos), 32'd0);
        chk("rst_tail", 32'(nxt_rob_pos), 32'd0);
        chk("rst_reg_write", 32'(reg_write), 32'd0);
        chk("rst_pc_en", 32'(if_set_pc_en), 32'd0);

        for (int i = 0; i < 16; i++) begin
            put(5'(i), OP_ADD, 32'(i * 4), 1'b0, 1'b0);
            #1;
            chk("fill_full", 32'(rob_nxt_full), (i == 15) ? 32'd1 : 32'd0);
            tick();
        end
        idle();
        #1;
        chk("full_hold", 32'(rob_nxt_full), 32'd1);
        chk("full_tail_wrap", 32'(nxt_rob_pos), 32'd0);
        cdb(0, 4'd0, 32'hAA, 1'b0, 32'd0);
        tick();
        idle();
        #1;
        chk("full_drop", 32'(rob_nxt_full), 32'd0);
        tick();
        chk("c0_write", 32'(reg_write), 32'd1);
        chk("c0_rd", 32'(reg_rd), 32'd0);
        chk("c0_val", reg_val, 32'hAA);
        chk("c0_pos", 32'(commit_rob_pos), 32'd0);
        chk("c0_head", 32'(head_rob_pos), 32'd1);

        do_reset();
        put(5'd5, OP_ADDI, 32'h10, 1'b0, 1'b1);
        cdb(0, 4'd0, 32'h9999, 1'b0, 32'd0);
        cdb(1, 4'd0, 32'h1234, 1'b0, 32'd0);
        tick();
        idle();
        chk("addi_early", 32'(reg_write), 32'd0);
        chk("addi_tail", 32'(nxt_rob_pos), 32'd1);
        tick();
        chk("addi_write", 32'(reg_write), 32'd1);
        chk("addi_rd", 32'(reg_rd), 32'd5);
        chk("addi_val", reg_val, 32'h1234);
        tick();
        chk("addi_pulse", 32'(reg_write), 32'd0);
        chk("addi_rd_hold", 32'(reg_rd), 32'd5);
        chk("addi_head", 32'(head_rob_pos), 32'd1);

        do_reset();
        put(5'd1, OP_ADD, 32'h0, 1'b0, 1'b0);
        tick();
        put(5'd2, OP_ADD, 32'h4, 1'b0, 1'b0);
        tick();
        idle();
        cdb(0, 4'd0, 32'h11, 1'b0, 32'd0);
        cdb(1, 4'd1, 32'h22, 1'b0, 32'd0);
        tick();
        idle();
        tick();
        chk("w2_write", 32'(d2_reg_write), 32'd3);
        chk("w2_rd", 32'(d2_reg_rd), 32'({5'd2, 5'd1}));
        chk("w2_val0", d2_reg_val[31:0], 32'h11);
        chk("w2_val1", d2_reg_val[63:32], 32'h22);
        chk("w2_pos", 32'(d2_cpos), 32'd0);
        chk("w1_first", 32'(reg_rd), 32'd1);
        put(5'd3, OP_ADD, 32'h8, 1'b0, 1'b0);
        tick();
        chk("w1_second", 32'(reg_rd), 32'd2);
        chk("w1_second_pos", 32'(commit_rob_pos), 32'd1);
        put(5'd0, OP_S, 32'hC, 1'b0, 1'b0);
        tick();
        idle();
        cdb(0, 4'd2, 32'h33, 1'b0, 32'd0);
        cdb(1, 4'd3, 32'h0, 1'b0, 32'd0);
        tick();
        idle();
        tick();
        chk("w2s_write", 32'(d2_reg_write), 32'd1);
        chk("w2s_rd", 32'(d2_reg_rd[4:0]), 32'd3);
        chk("w2s_val", d2_reg_val[31:0], 32'h33);
        chk("w2s_nostore", 32'(d2_lsb_store), 32'd0);
        chk("w2s_pos", 32'(d2_cpos), 32'd2);
        tick();
        chk("w2s_store", 32'(d2_lsb_store), 32'd1);
        chk("w2s_store_nowr", 32'(d2_reg_write), 32'd0);
        chk("w2s_store_pos", 32'(d2_cpos), 32'd3);
        tick();
        chk("w2s_store_pulse", 32'(d2_lsb_store), 32'd0);

        do_reset();
        put(5'd0, OP_BR, 32'h40, 1'b0, 1'b0);
        tick();
        put(5'd7, OP_ADD, 32'h44, 1'b0, 1'b1);
        cdb(0, 4'd0, 32'h0, 1'b1, 32'h80);
        tick();
        idle();
        tick();
        chk("br_commit", 32'(commit_br), 32'd1);
        chk("br_jump", 32'(commit_br_jump), 32'd1);
        chk("br_pc", commit_br_pc, 32'h40);
        chk("br_nowrite", 32'(reg_write), 32'd0);
        chk("br_rollback", 32'(rollback), 32'd1);
        chk("br_pc_en", 32'(if_set_pc_en), 32'd1);
        chk("br_set_pc", if_set_pc, 32'h80);
        chk("br2_rollback", 32'(d2_rollback), 32'd1);
        rs1_pos = 4'd1;
        tick();
        chk("rb_pulse", 32'(rollback), 32'd0);
        chk("rb_pc_en", 32'(if_set_pc_en), 32'd0);
        chk("rb_head", 32'(head_rob_pos), 32'd0);
        chk("rb_tail", 32'(nxt_rob_pos), 32'd0);
        chk("rb_nowrite", 32'(reg_write), 32'd0);
        chk("rb_ready_clr", 32'(rs1_ready), 32'd0);

        do_reset();
        for (int k = 0; k < 42; k++) begin
            if (k < 40)
                put(5'((k % 31) + 1), OP_ADD, 32'(k * 4), 1'b0, 1'b1);
            else
                idle();
            #1;
            chk("wrap_full", 32'(rob_nxt_full), 32'd0);
            if (k >= 2) begin
                chk("wrap_write", 32'(reg_write), 32'd1);
                chk("wrap_pos", 32'(commit_rob_pos), 32'((k - 2) % 16));
                chk("wrap_rd", 32'(reg_rd), 32'(((k - 2) % 31) + 1));
            end
            tick();
        end
        idle();

        do_reset();
        for (int i = 0; i < 4; i++) begin
            put(5'(i + 1), OP_ADD, 32'(i * 4), 1'b0, 1'b0);
            tick();
        end
        idle();
        rs1_pos = 4'd3;
        rs2_pos = 4'd2;
        cdb(0, 4'd3, 32'h55, 1'b0, 32'd0);
        #1;
`ifdef ROB_BYPASS_EN
        chk("byp_ready", 32'(rs1_ready), 32'd1);
        chk("byp_val", rs1_val, 32'h55);
`else
        chk("nobyp_ready", 32'(rs1_ready), 32'd0);
`endif
        tick();
        idle();
        #1;
        chk("q_ready", 32'(rs1_ready), 32'd1);
        chk("q_val", rs1_val, 32'h55);
        chk("q_other", 32'(rs2_ready), 32'd0);

        rdy = 1'b0;
        rs2_pos = 4'd0;
        cdb(0, 4'd0, 32'h77, 1'b0, 32'd0);
        put(5'd9, OP_ADD, 32'h0, 1'b0, 1'b1);
        tick();
        tick();
        idle();
        rdy = 1'b1;
        #1;
        chk("frz_ready", 32'(rs2_ready), 32'd0);
        chk("frz_head", 32'(head_rob_pos), 32'd0);
        chk("frz_tail", 32'(nxt_rob_pos), 32'd4);
        chk("frz_write", 32'(reg_write), 32'd0);

        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end
endmodule
